// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM-to-memory image loader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rom_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs ROM bytes into one little-endian word; lanes never written since the last clear stay zero.
// Latency: a captured byte is visible in word on the following cycle.
// Backpressure: none; the owner simply stops asserting capture while the word is held.
module byte_packer
    import rom_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      capture,
    input  logic [1:0]                lane,
    input  logic [7:0]                byte_in,
    input  logic                      clear,
    output logic [8*WORD_BYTES-1:0]   word
);

    // Clear wins over capture so a fresh word always starts from all-zero lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (capture) begin
            word[{lane, 3'b000} +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams a byte-wide combinational ROM image into word-wide memory writes at BASE_ADDRESS.
// Latency: one byte per FETCH cycle, one WRITE cycle per word (5 cycles/word with ready high).
// Backpressure: mem_write_ready low holds WRITE with address/data/valid and rom_address frozen.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write_valid,
    input  logic        mem_write_ready,
    output logic        busy,
    output logic        load_done
);

    state_t      state;
    state_t      state_nxt;
    logic [29:0] word_index;
    logic        last_word;
    logic [31:0] packed_word;
    logic        handshake;
    logic        pack_clear;

    assign handshake  = (state == WRITE) && mem_write_ready;
    assign pack_clear = ((state == IDLE) && start) || handshake;

    byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (state == FETCH),
        .lane    (rom_address[1:0]),
        .byte_in (rom_byte),
        .clear   (pack_clear),
        .word    (packed_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and outputs; write outputs are gated to zero outside WRITE so reset shows zeros.
    always_comb begin
        state_nxt       = state;
        mem_write_valid = 1'b0;
        mem_address     = 32'd0;
        mem_data        = 32'd0;
        busy            = 1'b0;
        load_done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if ((rom_address[1:0] == LAST_LANE) || rom_done) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy            = 1'b1;
                mem_write_valid = 1'b1;
                mem_address     = BASE_ADDRESS + {word_index, 2'b00};
                mem_data        = packed_word;
                if (mem_write_ready) begin
                    state_nxt = last_word ? DONE : FETCH;
                end
            end
            DONE: begin
                load_done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ROM address walk, word counter and end-of-image flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_address <= 32'd0;
            word_index  <= 30'd0;
            last_word   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_address <= 32'd0;
                        word_index  <= 30'd0;
                        last_word   <= 1'b0;
                    end
                end
                FETCH: begin
                    // The last image byte parks the address; the word is still written.
                    if (rom_done) begin
                        last_word <= 1'b1;
                    end else begin
                        rom_address <= rom_address + 32'd1;
                    end
                end
                WRITE: begin
                    if (mem_write_ready && !last_word) begin
                        word_index <= word_index + 30'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rom_address;
    logic [7:0]  rom_byte;
    logic        rom_done;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write_valid;
    logic        mem_write_ready = 1'b1;
    logic        busy;
    logic        load_done;

    int          total = 0;
    int          bad = 0;
    int          mode = 0;
    logic [31:0] rom_w;

    always #5 clk = ~clk;

    rom_loader #(.BASE_ADDRESS(BASE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .rom_address     (rom_address),
        .rom_byte        (rom_byte),
        .rom_done        (rom_done),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_write_valid (mem_write_valid),
        .mem_write_ready (mem_write_ready),
        .busy            (busy),
        .load_done       (load_done)
    );

    // 224-byte image: 56 words, word 0 = 1, word 3 = 500000.
    function automatic logic [31:0] img_word(input int n);
        case (n)
            0:       return 32'h0000_0001;
            3:       return 32'h0007_A120;
            default: return 32'hA500_0000 + 32'(n) * 32'h0001_0307;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input int m, input int n);
        if (m == 0) return img_word(n);
        if (n == 0) return 32'h1413_1211;
        return 32'h0000_1615;
    endfunction

    // Combinational program ROM model.
    always_comb begin
        rom_w    = img_word(int'(rom_address >> 2));
        rom_byte = 8'h00;
        rom_done = 1'b0;
        if (mode == 0) begin
            rom_byte = rom_w[{rom_address[1:0], 3'b000} +: 8];
            rom_done = (rom_address == 32'd223);
        end else begin
            rom_byte = (rom_address <= 32'd5) ? (8'h11 + rom_address[7:0]) : 8'h00;
            rom_done = (rom_address == 32'd5);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mem_write_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(mem_write_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_rom_addr", rom_address, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one load from start; cycle 0 is the cycle start is high.
    task automatic run_load(input int stall_lo, input int stall_hi, input int pulse_cyc,
                            input int exp_writes, input int exp_done);
        int writes;
        int done_cyc;
        writes   = 0;
        done_cyc = -1;
        start = 1'b1;
        mem_write_ready = 1'b1;
        chk("idle_busy", 32'(busy), 32'd0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = (cyc == pulse_cyc);
            mem_write_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (cyc == 1) chk("fetch_busy", 32'(busy), 32'd1);
            if (cyc >= stall_lo && cyc <= stall_hi + 1) begin
                chk("stall_valid", 32'(mem_write_valid), 32'd1);
                chk("stall_addr", mem_address, BASE + 32'(4 * writes));
                chk("stall_data", mem_data, exp_word(mode, writes));
                chk("stall_rom_addr", rom_address, 32'(4 * (writes + 1)));
            end
            if (mem_write_valid && mem_write_ready) begin
                chk("wr_addr", mem_address, BASE + 32'(4 * writes));
                chk("wr_data", mem_data, exp_word(mode, writes));
                writes++;
            end
            if (load_done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        mem_write_ready = 1'b1;
        chk("write_count", 32'(writes), 32'(exp_writes));
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(mem_write_valid), 32'd0);
    endtask

    task automatic done_pulse(input logic [31:0] exp_rom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("donep_done", 32'(load_done), 32'd1);
        chk("donep_busy", 32'(busy), 32'd0);
        chk("donep_valid", 32'(mem_write_valid), 32'd0);
        chk("donep_rom_addr", rom_address, exp_rom);
        chk("donep_mem_addr", mem_address, 32'd0);
    endtask

    initial begin
        // Reset state.
        mode = 0;
        do_reset();

        // Full 224-byte image, ready high, start re-pulsed during FETCH.
        run_load(-10, -10, 2, 56, 281);
        done_pulse(32'd223);

        // Word 1 stalled by 3 cycles of ready low.
        do_reset();
        run_load(10, 12, -1, 56, 284);

        // Short image ending at address 5 -> partial second word.
        mode = 1;
        do_reset();
        run_load(-10, -10, 3, 2, 9);
        done_pulse(32'd5);

        // Reset during WRITE of word 10, then full reload from address 0.
        mode = 0;
        do_reset();
        start = 1'b1;
        for (int cyc = 1; cyc <= 55; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_valid_pre", 32'(mem_write_valid), 32'd1);
        chk("abort_addr_pre", mem_address, BASE + 32'd40);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(mem_write_valid), 32'd0);
        chk("abort_done", 32'(load_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_addr", mem_address, 32'd0);
        chk("abort_mem_data", mem_data, 32'd0);
        chk("abort_rom_addr", rom_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(-10, -10, -1, 56, 281);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'd0, the memory byte address written with word 0.
REQ-002 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin loading, sampled only in IDLE.
REQ-005 SHALL have port rom_address  output  32  byte address presented to the combinational program ROM.
REQ-006 SHALL have port rom_byte  input  8  ROM data for rom_address, valid in the same cycle.
REQ-007 SHALL have port rom_done  input  1  high when rom_address is the last image byte.
REQ-008 SHALL have port mem_address  output  32  word-aligned memory write address.
REQ-009 SHALL have port mem_data  output  32  packed write word, little-endian.
REQ-010 SHALL have port mem_write_valid  output  1  write request, held until accepted.
REQ-011 SHALL have port mem_write_ready  input  1  memory accepts the write when high together with valid.
REQ-012 SHALL have port busy  output  1  high in FETCH or WRITE.
REQ-013 SHALL have port load_done  output  1  high once the whole image is written.

Function
REQ-014 SHALL implement states IDLE, FETCH, WRITE, DONE.
REQ-015 IDLE -> FETCH when start=1; rom_address=0, packing lane=0, word index=0 on entry.
REQ-016 FETCH: each cycle SHALL capture rom_byte into lane rom_address[1:0] (lane 0 = bits 7:0), then rom_address+1 unless rom_done.
REQ-017 FETCH -> WRITE after capturing lane 3 or any byte with rom_done=1.
REQ-018 Lanes not captured in a final partial word SHALL read as zero.
REQ-019 WRITE: mem_write_valid=1, mem_address=BASE_ADDRESS+4*word_index, mem_data stable until handshake.
REQ-020 Handshake = mem_write_valid & mem_write_ready in same cycle; exactly one write per word.
REQ-021 On handshake: if the word held the rom_done byte -> DONE, else word_index+1, packing buffer cleared, -> FETCH.
REQ-022 mem_write_ready low SHALL stall in WRITE indefinitely with all outputs held; rom_address not advanced.
REQ-023 DONE: load_done=1, busy=0, valid=0; remains until reset; start ignored.
REQ-024 start in FETCH/WRITE/DONE SHALL be ignored.
REQ-025 With ready tied high, each full word costs 5 cycles (4 FETCH + 1 WRITE).
REQ-026 rom_address arithmetic 32-bit; no wrap handling required beyond natural modulo 2^32.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, rom_address=0, mem_address=0, mem_data=0, mem_write_valid=0, busy=0, load_done=0.
REQ-028 Reset mid-load SHALL abandon the pending write with no further valid; new start reloads from address 0.

Structure
REQ-029 Package rom_loader_pkg SHALL hold the state enum and WORD_BYTES=4.
REQ-030 One sub-module byte_packer (lane capture, zero-fill, clear) is natural; FSM and counters stay in rom_loader.

Verification
REQ-031 224-byte image (rom_done at 223), ready=1, start at cycle 0 -> 56 writes, word0 0x00000001 @BASE, word3 0x0007A120 @BASE+12, load_done at cycle 281.
REQ-032 ready low 3 cycles during word 1 -> mem_address/mem_data/valid held 4 cycles, single write, rom_address stays 8.
REQ-033 rom_done at address 5, bytes 0x11..0x16 -> 2 writes: 0x14131211, 0x00001615; then DONE.
REQ-034 rst_n low during WRITE of word 10 -> valid drops asynchronously, load_done=0; restart writes word0 again at BASE.
REQ-035 start pulsed in FETCH and in DONE -> no state, address or output change.
REQ-036 BASE_ADDRESS=32'h1000 -> word n written at 32'h1000+4n.
